if_prefetch: RTL and testbench
==============================

# if_prefetch

Instruction-fetch stage with a small prefetch buffer for the MIPS core. Sits between the program counter and the instruction memory on the upstream side, and the decode stage on the downstream side. Issues word-addressed read requests to instruction memory over a req/ack handshake and buffers returned instructions with their PC. Presents them to decode over a valid/ready interface and flushes on branch/jump redirects.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, minimum 2.
- `ADDR_W`, 32: PC / instruction-memory address width; PC is a word index.
- `RESET_PC`, 0: first fetch address after reset or `clr`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush; restart fetching at `RESET_PC`.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  ADDR_W  target word address.
- `imem_req`  out  1  read request.
- `imem_addr`  out  ADDR_W  word address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  read data valid this cycle; may arrive in the same cycle as the request.
- `imem_rdata`  in  32  instruction word.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  ADDR_W  head instruction address.
- `pc_out`  out  ADDR_W  next fetch address.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response kept.
  - DISCARD: request outstanding, response to be dropped.
- IDLE → WAIT: issue when `count + 1 <= DEPTH`. The request counts as in-flight, so at most one request is outstanding and the FIFO never overflows.
- WAIT, on `imem_ack`:
  - Push `{imem_rdata, fetch_pc}` and set `fetch_pc <= fetch_pc + 1` (wraps modulo 2^ADDR_W).
  - If space remains, go back-to-back to WAIT with the new address next cycle; otherwise go to IDLE.
- Redirect:
  - FIFO is emptied and `fetch_pc <= redirect_pc`.
  - From WAIT without ack: go to DISCARD. The outstanding handshake completes and the returned data is dropped.
  - From DISCARD: `fetch_pc` is updated again and the FSM stays in DISCARD.
  - Ack in the same cycle as the redirect: data is dropped and the FSM goes to IDLE.
- DISCARD → IDLE on `imem_ack`, with no push.
- Output side:
  - `out_valid = count != 0`.
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- A pop in the same cycle as a redirect completes, then the flush applies.
- `clr` behaves as a redirect to `RESET_PC` and has priority over `redirect_valid`.
- While `imem_req`=1 and no ack has arrived, `imem_addr` must not change, even on a redirect.

## Timing
- Reset values:
  - `imem_req`=0, `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - `imem_addr`=`RESET_PC`, `pc_out`=`RESET_PC`.
  - FSM in IDLE, `count`=0.
- First `imem_req` is asserted in the first cycle after `rst` deasserts.
- Fetch latency: `out_valid` rises one cycle after the `imem_ack` that delivered the word.
- Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle once primed.
- Redirect penalty:
  - From IDLE or WAIT-with-ack: `imem_addr`=`redirect_pc` in the next cycle.
  - From DISCARD: `imem_addr`=`redirect_pc` in the cycle after the pending ack.
- Asserting `rst` mid-operation clears everything immediately. An outstanding memory response arriving after reset is ignored.

## Configuration
- `IF_PREFETCH_PERF_EN` defined: adds `perf_fetch_cnt` (32 b) and `perf_flush_cnt` (32 b) output ports.
  - Both reset to 0 and saturate at all-ones.
  - `perf_fetch_cnt` increments on every FIFO push.
  - `perf_flush_cnt` increments on every redirect or `clr`.
- Undefined: the ports and counters are absent.

## Structure
- `mips_pkg` holds:
  - `addr_t`, `instr_t`;
  - `fetch_state_e` {IDLE, WAIT, DISCARD};
  - the `RESET_PC` default constant.
- One sub-module, `if_fifo`: a synchronous FIFO of `{instr, pc}` with push, pop, flush and count outputs.
- The FSM and `fetch_pc` live in `if_prefetch`.

## Test plan
- Reset, then zero-wait memory returning `32'h20C60001` at address 0 with `out_ready`=1 → `out_pc` sequence 0,1,2,3… one per cycle after the first.
- `out_ready`=0 with zero-wait memory → 4 pushes, `imem_req` drops, `pc_out`=4. Raise `out_ready` → fetching resumes at 4 with no duplicate or lost instruction.
- 3-cycle ack latency, redirect to 7 while waiting → the stale word is dropped, the next `imem_addr`=7, and the first `out_pc`=7.
- Redirect to 2 in the same cycle as an ack and a pop → the popped instruction is delivered once, the acked word is dropped, and `out_valid`=0 next cycle.
- `fetch_pc`=`32'hFFFFFFFF` → next `pc_out`=0, and `clr` asserted together with `redirect_valid` restarts at `RESET_PC`.
- Assert `rst` mid-WAIT, then ack arrives → no push, all outputs at reset values; with `IF_PREFETCH_PERF_EN`, counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS fetch front end.
package mips_pkg;
  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [31:0]           instr_t;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/ack channel plus the decode-facing valid/ready channel.
interface if_prefetch_if #(parameter int ADDR_W = 32);
  import mips_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  instr_t            imem_rdata;
  logic              out_valid;
  logic              out_ready;
  instr_t            out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_ack, imem_rdata, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/if_fifo.sv
// Small synchronous FIFO of {instr, pc} entries with flush and occupancy count.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  // Head is forced to zero when empty so the outputs read zero after reset/flush.
  assign rdata  = (count != '0) ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/if_prefetch.sv
// Fetch stage: one-outstanding imem requester feeding a prefetch FIFO toward decode.
// Define IF_PREFETCH_PERF_EN to add saturating fetch/flush performance counters.
module if_prefetch
  import mips_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  if_prefetch_if.master      bus,
  output logic [ADDR_W-1:0]  pc_out
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, hold_addr, flush_pc;
  logic [CW-1:0]     count;
  logic              flush, push, pop, room_after_push;
  logic [31+ADDR_W:0] head;

  assign flush    = clr | redirect_valid;
  assign flush_pc = clr ? RESET_PC : redirect_pc;
  assign pop      = bus.out_valid && bus.out_ready;
  assign push     = (state == WAIT) && bus.imem_ack && !flush;
  // After this push (and any pop) there must still be a slot for the next in-flight word.
  assign room_after_push = (count - CW'(pop)) < CW'(DEPTH - 1);

  if_fifo #(.DEPTH(DEPTH), .W(32 + ADDR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.imem_rdata, fetch_pc}),
    .rdata (head),
    .count (count)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head[ADDR_W +: 32];
  assign bus.out_pc    = head[ADDR_W-1:0];
  assign pc_out        = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (flush || count < CW'(DEPTH)) state_nxt = WAIT;
      WAIT:    if (bus.imem_ack) state_nxt = (!flush && room_after_push) ? WAIT : IDLE;
               else if (flush)   state_nxt = DISCARD;
      DISCARD: if (bus.imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = fetch_pc;
    unique case (state)
      WAIT:    bus.imem_req = 1'b1;
      // fetch_pc already points at the redirect target; keep presenting the old address.
      DISCARD: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = hold_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      if (flush)                             fetch_pc <= flush_pc;
      else if (state == WAIT && bus.imem_ack) fetch_pc <= fetch_pc + 1'b1;
      if (state == WAIT && !bus.imem_ack && flush) hold_addr <= fetch_pc;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push)  perf_fetch_cnt <= sat_inc32(perf_fetch_cnt);
      if (flush) perf_flush_cnt <= sat_inc32(perf_flush_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: directed stimulus queues expected {instr, pc}, a monitor checks pops.
`timescale 1ns/1ps
module tb_if_prefetch;
  import mips_pkg::*;
  localparam int ADDR_W = 32;

  typedef struct packed {
    instr_t            instr;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] pc_out;
  logic              out_ready = 1'b0;
  logic              force_ack = 1'b0;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0]       perf_fetch_cnt, perf_flush_cnt;
`endif

  if_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

  if_prefetch #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .pc_out         (pc_out)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic instr_t instr_of(input logic [ADDR_W-1:0] a);
    return 32'h20C60001 ^ {a[23:0], 8'h00};
  endfunction

  // Memory model: ack after `lat` waiting cycles; lat=0 acks in the request cycle.
  int lat = 0;
  int wait_cnt = 0;
  assign bus.imem_ack   = force_ack | (bus.imem_req && (wait_cnt >= lat));
  assign bus.imem_rdata = instr_of(bus.imem_addr);
  assign bus.out_ready  = out_ready;
  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else                               wait_cnt <= 0;
  end

  exp_t              sb_q[$];
  logic [ADDR_W-1:0] ack_addrs[$];
  int checks = 0, errors = 0;
  int cyc = 0, first_pop = -1, last_pop = -1;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_req && bus.imem_ack) ack_addrs.push_back(bus.imem_addr);
    if (bus.out_valid && bus.out_ready) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no output", bus.out_pc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_pc", 64'(bus.out_pc), 64'(mon_e.pc));
        chk("sb_instr", 64'(bus.out_instr), 64'(mon_e.instr));
      end
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.instr = instr_of(a);
    e.pc    = a;
    sb_q.push_back(e);
  endtask

  // Callers sit just after a rising edge; reset is asserted right away.
  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    clr = 1'b0;
    redirect_valid = 1'b0;
    force_ack = 1'b0;
    first_pop = -1;
    ack_addrs.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d entries left expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_req",   64'(bus.imem_req),  64'(0));
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_instr", 64'(bus.out_instr), 64'(0));
    chk("rst_outpc", 64'(bus.out_pc),    64'(0));
    chk("rst_addr",  64'(bus.imem_addr), 64'(0));
    chk("rst_pcout", 64'(pc_out),        64'(0));
`ifdef IF_PREFETCH_PERF_EN
    chk("rst_perf_fetch", 64'(perf_fetch_cnt), 64'(0));
    chk("rst_perf_flush", 64'(perf_flush_cnt), 64'(0));
`endif

    // Zero-wait memory streaming into a ready decoder.
    lat = 0; out_ready = 1'b1; first_pop = -1;
    for (int i = 0; i < 8; i++) push_exp(ADDR_W'(i));
    release_rst();
    @(posedge clk);
    @(negedge clk);
    chk("t1_first_req",  64'(bus.imem_req),  64'(1));
    chk("t1_first_addr", 64'(bus.imem_addr), 64'(0));
    drain("t1", 40);
    chk("t1_rate", 64'(last_pop - first_pop), 64'(7));
    do_reset();

    // Stalled decoder fills the FIFO, then resumes.
    lat = 0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_exp(ADDR_W'(i));
    release_rst();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t2_req_low", 64'(bus.imem_req),  64'(0));
    chk("t2_pc_out",  64'(pc_out),        64'(4));
    chk("t2_valid",   64'(bus.out_valid), 64'(1));
    chk("t2_head",    64'(bus.out_pc),    64'(0));
`ifdef IF_PREFETCH_PERF_EN
    chk("t2_perf_fetch", 64'(perf_fetch_cnt), 64'(4));
`endif
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("t2", 60);
    do_reset();

    // 3-cycle memory, redirect to 7 while the word for 0 is outstanding.
    lat = 3; out_ready = 1'b1;
    push_exp(7); push_exp(8);
    release_rst();
    @(posedge clk);
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 7;
    @(negedge clk);
    chk("t3_addr_hold_a", 64'(bus.imem_addr), 64'(0));
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_addr_hold_b", 64'(bus.imem_addr), 64'(0));
    chk("t3_req_held",    64'(bus.imem_req),  64'(1));
    chk("t3_pc_out",      64'(pc_out),        64'(7));
    drain("t3", 80);
    chk("t3_ack0", 64'((ack_addrs.size() > 0) ? ack_addrs[0] : 32'hDEAD_BEEF), 64'(0));
    chk("t3_ack1", 64'((ack_addrs.size() > 1) ? ack_addrs[1] : 32'hDEAD_BEEF), 64'(7));
    do_reset();

    // Redirect to 2 in the same cycle as an ack (of 2) and a pop (of 1).
    lat = 0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(ADDR_W'(i));
    release_rst();
    repeat (3) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 2;
    @(negedge clk);
    chk("t4_ack_pop", 64'({bus.imem_ack, bus.out_valid}), 64'(2'b11));
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid_low", 64'(bus.out_valid), 64'(0));
    chk("t4_addr",      64'(bus.imem_addr), 64'(2));
    drain("t4", 40);
    do_reset();

    // PC wrap, then clr together with a redirect.
    lat = 0; out_ready = 1'b0;
    release_rst();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_wrap_pcout", 64'(pc_out),        64'(0));
    chk("t5_head_pc",    64'(bus.out_pc),    64'(32'hFFFF_FFFF));
    chk("t5_head_instr", 64'(bus.out_instr), 64'(32'hDF39_FF01));
    @(posedge clk);
    #1 clr = 1'b1; redirect_valid = 1'b1; redirect_pc = 5;
    @(posedge clk);
    #1 clr = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_clr_pcout", 64'(pc_out),        64'(0));
    chk("t5_clr_addr",  64'(bus.imem_addr), 64'(0));
    chk("t5_clr_valid", 64'(bus.out_valid), 64'(0));
`ifdef IF_PREFETCH_PERF_EN
    chk("t5_perf_flush", 64'(perf_flush_cnt), 64'(2));
    chk("t5_perf_fetch", 64'(perf_fetch_cnt), 64'(2));
`endif
    push_exp(0); push_exp(1); push_exp(2);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("t5", 40);
    do_reset();

    // Reset while a request is outstanding; a late ack must be ignored.
    lat = 2; out_ready = 1'b1;
    release_rst();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    chk("t6_req",   64'(bus.imem_req),  64'(0));
    chk("t6_valid", 64'(bus.out_valid), 64'(0));
    chk("t6_instr", 64'(bus.out_instr), 64'(0));
    chk("t6_outpc", 64'(bus.out_pc),    64'(0));
    chk("t6_addr",  64'(bus.imem_addr), 64'(0));
    chk("t6_pcout", 64'(pc_out),        64'(0));
`ifdef IF_PREFETCH_PERF_EN
    chk("t6_perf_fetch", 64'(perf_fetch_cnt), 64'(0));
    chk("t6_perf_flush", 64'(perf_flush_cnt), 64'(0));
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    chk("t6_no_push", 64'(bus.out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
